// File: rtl/mem_lsu.sv
// MEM pipeline stage: registered ALU pass-through plus a req/ack load/store unit
// with sub-word access, alignment checking and bus error/timeout termination.

module mem_lsu #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned RADDR_WIDTH    = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    valid_i,
  input  logic [3:0]              mem_op_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [RADDR_WIDTH-1:0]  reg_waddr_i,
  input  logic                    reg_we_i,
  input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
  output logic                    stall_o,
  output logic                    dmem_req_o,
  output logic                    dmem_we_o,
  output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
  output logic [DATA_WIDTH/8-1:0] dmem_be_o,
  output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
  input  logic                    dmem_ack_i,
  input  logic                    dmem_err_i,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
  output logic                    valid_o,
  output logic [RADDR_WIDTH-1:0]  reg_waddr_o,
  output logic                    reg_we_o,
  output logic [DATA_WIDTH-1:0]   reg_wdata_o,
  output logic                    exc_misaligned_o,
  output logic                    exc_fault_o
);

  localparam int unsigned   NB       = DATA_WIDTH / 8;
  localparam int unsigned   OFFW     = $clog2(NB);
  localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit            IS64     = (DATA_WIDTH == 64);

  typedef enum logic {S_IDLE, S_BUS} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lat_load_q, lat_load_d;
  logic                   lat_sgn_q, lat_sgn_d;
  size_e                  lat_size_q, lat_size_d;
  logic [OFFW-1:0]        lat_off_q, lat_off_d;
  logic [RADDR_WIDTH-1:0] lat_waddr_q, lat_waddr_d;

  logic                   valid_q, valid_d;
  logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                   reg_we_q, reg_we_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   exc_mis_q, exc_mis_d;
  logic                   exc_flt_q, exc_flt_d;
  logic                   req_q, req_d;
  logic                   dwe_q, dwe_d;
  logic [ADDR_WIDTH-1:0]  daddr_q, daddr_d;
  logic [NB-1:0]          be_q, be_d;
  logic [DATA_WIDTH-1:0]  dwdata_q, dwdata_d;

  logic                   dec_load, dec_store, dec_sgn;
  size_e                  dec_size;
  logic                   mem_access, misaligned, start, timeout, stall;
  logic [OFFW-1:0]        off;
  logic [NB-1:0]          be_base;
  logic [DATA_WIDTH-1:0]  st_repl;
  logic [DATA_WIDTH-1:0]  ld_shift, ld_data;
  int unsigned            ld_bits;
  logic                   ld_msb;

  // Op decode; 64-bit ops collapse to NONE in a 32-bit build.
  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_sgn   = 1'b0;
    dec_size  = SZ_B;
    case (mem_op_i)
      4'd1:  begin dec_load = 1'b1; dec_sgn = 1'b1; end
      4'd2:  begin dec_load = 1'b1; dec_sgn = 1'b1; dec_size = SZ_H; end
      4'd3:  begin dec_load = 1'b1; dec_sgn = 1'b1; dec_size = SZ_W; end
      4'd4:  dec_load = 1'b1;
      4'd5:  begin dec_load = 1'b1; dec_size = SZ_H; end
      4'd6:  dec_store = 1'b1;
      4'd7:  begin dec_store = 1'b1; dec_size = SZ_H; end
      4'd8:  begin dec_store = 1'b1; dec_size = SZ_W; end
      4'd9:  if (IS64) begin dec_load = 1'b1; dec_size = SZ_W; end
      4'd10: if (IS64) begin dec_load = 1'b1; dec_size = SZ_D; end
      4'd11: if (IS64) begin dec_store = 1'b1; dec_size = SZ_D; end
      default: ;
    endcase
  end

  assign mem_access = dec_load | dec_store;
  assign off        = mem_addr_i[OFFW-1:0];

  always_comb begin
    case (dec_size)
      SZ_H:    misaligned = mem_addr_i[0];
      SZ_W:    misaligned = |mem_addr_i[1:0];
      SZ_D:    misaligned = |mem_addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign start = valid_i & mem_access & ~misaligned;

  // Lane steering for stores: enables shifted into the addressed lane, data replicated.
  always_comb begin
    case (dec_size)
      SZ_B:    begin be_base = NB'(4'h1); st_repl = {NB{mem_wdata_i[7:0]}};        end
      SZ_H:    begin be_base = NB'(4'h3); st_repl = {(NB/2){mem_wdata_i[15:0]}};   end
      SZ_W:    begin be_base = NB'(4'hF); st_repl = {(NB/4){mem_wdata_i[31:0]}};   end
      default: begin be_base = '1;        st_repl = mem_wdata_i;                   end
    endcase
  end

  // Load return: bring the addressed lane to bit 0, then extend above the access size.
  assign ld_shift = dmem_rdata_i >> {lat_off_q, 3'b000};

  always_comb begin
    case (lat_size_q)
      SZ_B:    begin ld_bits = 8;          ld_msb = ld_shift[7];  end
      SZ_H:    begin ld_bits = 16;         ld_msb = ld_shift[15]; end
      SZ_W:    begin ld_bits = 32;         ld_msb = ld_shift[31]; end
      default: begin ld_bits = DATA_WIDTH; ld_msb = 1'b0;         end
    endcase
    ld_data = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      ld_data[i] = (i < ld_bits) ? ld_shift[i] : (lat_sgn_q & ld_msb);
    end
  end

  // An ack on the final counted cycle suppresses the timeout.
  assign timeout = (TIMEOUT_CYCLES != 0) && (state_q == S_BUS) &&
                   (cnt_q == CNT_LAST) && !dmem_ack_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_load_q  <= 1'b0;
      lat_sgn_q   <= 1'b0;
      lat_size_q  <= SZ_B;
      lat_off_q   <= '0;
      lat_waddr_q <= '0;
      valid_q     <= 1'b0;
      waddr_q     <= '0;
      reg_we_q    <= 1'b0;
      wdata_q     <= '0;
      exc_mis_q   <= 1'b0;
      exc_flt_q   <= 1'b0;
      req_q       <= 1'b0;
      dwe_q       <= 1'b0;
      daddr_q     <= '0;
      be_q        <= '0;
      dwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_load_q  <= lat_load_d;
      lat_sgn_q   <= lat_sgn_d;
      lat_size_q  <= lat_size_d;
      lat_off_q   <= lat_off_d;
      lat_waddr_q <= lat_waddr_d;
      valid_q     <= valid_d;
      waddr_q     <= waddr_d;
      reg_we_q    <= reg_we_d;
      wdata_q     <= wdata_d;
      exc_mis_q   <= exc_mis_d;
      exc_flt_q   <= exc_flt_d;
      req_q       <= req_d;
      dwe_q       <= dwe_d;
      daddr_q     <= daddr_d;
      be_q        <= be_d;
      dwdata_q    <= dwdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUS;
      S_BUS:   if (dmem_ack_i || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    valid_d     = 1'b0;
    reg_we_d    = 1'b0;
    exc_mis_d   = 1'b0;
    exc_flt_d   = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    req_d       = req_q;
    dwe_d       = dwe_q;
    daddr_d     = daddr_q;
    be_d        = be_q;
    dwdata_d    = dwdata_q;
    cnt_d       = cnt_q;
    lat_load_d  = lat_load_q;
    lat_sgn_d   = lat_sgn_q;
    lat_size_d  = lat_size_q;
    lat_off_d   = lat_off_q;
    lat_waddr_d = lat_waddr_q;
    case (state_q)
      S_IDLE: begin
        stall = start;
        if (valid_i) begin
          if (!mem_access) begin
            valid_d  = 1'b1;
            waddr_d  = reg_waddr_i;
            reg_we_d = reg_we_i;
            wdata_d  = reg_wdata_i;
          end else if (misaligned) begin
            valid_d   = 1'b1;
            waddr_d   = reg_waddr_i;
            exc_mis_d = 1'b1;
          end else begin
            lat_load_d  = dec_load;
            lat_sgn_d   = dec_sgn;
            lat_size_d  = dec_size;
            lat_off_d   = off;
            lat_waddr_d = reg_waddr_i;
            req_d       = 1'b1;
            dwe_d       = dec_store;
            daddr_d     = {mem_addr_i[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
            be_d        = be_base << off;
            dwdata_d    = st_repl;
            cnt_d       = '0;
          end
        end
      end
      S_BUS: begin
        stall = ~dmem_ack_i & ~timeout;
        if (dmem_ack_i) begin
          req_d   = 1'b0;
          dwe_d   = 1'b0;
          valid_d = 1'b1;
          waddr_d = lat_waddr_q;
          if (dmem_err_i) begin
            exc_flt_d = 1'b1;
          end else begin
            reg_we_d = lat_load_q;
            if (lat_load_q) wdata_d = ld_data;
          end
        end else if (timeout) begin
          req_d     = 1'b0;
          dwe_d     = 1'b0;
          valid_d   = 1'b1;
          waddr_d   = lat_waddr_q;
          exc_flt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign stall_o          = stall & rst_n_i;
  assign dmem_req_o       = req_q;
  assign dmem_we_o        = dwe_q;
  assign dmem_addr_o      = daddr_q;
  assign dmem_be_o        = be_q;
  assign dmem_wdata_o     = dwdata_q;
  assign valid_o          = valid_q;
  assign reg_waddr_o      = waddr_q;
  assign reg_we_o         = reg_we_q;
  assign reg_wdata_o      = wdata_q;
  assign exc_misaligned_o = exc_mis_q;
  assign exc_fault_o      = exc_flt_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: 32- and 64-bit instances, directed cases plus random ops
// checked each cycle against a transaction-level model of the stage.

module tb_mem_lsu;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  op;
  logic [31:0] addr;
  logic [63:0] wdata, rwdata, rdata;
  logic [4:0]  waddr;
  logic        rwe, err, v32, v64, ack32, ack64;

  logic        s32, rq32, dwe32, vo32, rwe32, mis32, flt32;
  logic [31:0] da32, dwd32, ro32;
  logic [3:0]  be32;
  logic [4:0]  wa32;
  logic        s64, rq64, dwe64, vo64, rwe64, mis64, flt64;
  logic [31:0] da64;
  logic [63:0] dwd64, ro64;
  logic [7:0]  be64;
  logic [4:0]  wa64;

  mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RADDR_WIDTH(5), .TIMEOUT_CYCLES(TO)) u32 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(v32), .mem_op_i(op), .mem_addr_i(addr),
    .mem_wdata_i(wdata[31:0]), .reg_waddr_i(waddr), .reg_we_i(rwe), .reg_wdata_i(rwdata[31:0]),
    .stall_o(s32), .dmem_req_o(rq32), .dmem_we_o(dwe32), .dmem_addr_o(da32), .dmem_be_o(be32),
    .dmem_wdata_o(dwd32), .dmem_ack_i(ack32), .dmem_err_i(err), .dmem_rdata_i(rdata[31:0]),
    .valid_o(vo32), .reg_waddr_o(wa32), .reg_we_o(rwe32), .reg_wdata_o(ro32),
    .exc_misaligned_o(mis32), .exc_fault_o(flt32));

  mem_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .RADDR_WIDTH(5), .TIMEOUT_CYCLES(TO)) u64 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(v64), .mem_op_i(op), .mem_addr_i(addr),
    .mem_wdata_i(wdata), .reg_waddr_i(waddr), .reg_we_i(rwe), .reg_wdata_i(rwdata),
    .stall_o(s64), .dmem_req_o(rq64), .dmem_we_o(dwe64), .dmem_addr_o(da64), .dmem_be_o(be64),
    .dmem_wdata_o(dwd64), .dmem_ack_i(ack64), .dmem_err_i(err), .dmem_rdata_i(rdata),
    .valid_o(vo64), .reg_waddr_o(wa64), .reg_we_o(rwe64), .reg_wdata_o(ro64),
    .exc_misaligned_o(mis64), .exc_fault_o(flt64));

  bit sel64 = 1'b0;
  logic        o_stall, o_req, o_bwe, o_valid, o_rwe, o_mis, o_flt;
  logic [31:0] o_baddr;
  logic [7:0]  o_be;
  logic [63:0] o_bdata, o_wdata;
  logic [4:0]  o_waddr;
  assign o_stall = sel64 ? s64 : s32;
  assign o_req   = sel64 ? rq64 : rq32;
  assign o_bwe   = sel64 ? dwe64 : dwe32;
  assign o_baddr = sel64 ? da64 : da32;
  assign o_be    = sel64 ? be64 : {4'b0, be32};
  assign o_bdata = sel64 ? dwd64 : {32'b0, dwd32};
  assign o_valid = sel64 ? vo64 : vo32;
  assign o_rwe   = sel64 ? rwe64 : rwe32;
  assign o_waddr = sel64 ? wa64 : wa32;
  assign o_wdata = sel64 ? ro64 : {32'b0, ro32};
  assign o_mis   = sel64 ? mis64 : mis32;
  assign o_flt   = sel64 ? flt64 : flt32;

  typedef struct {
    longint unsigned due;
    bit              we, mis, flt, chk;
    logic [4:0]      wa;
    logic [63:0]     d;
  } res_t;
  res_t q[$];

  bit              chk_en = 1'b0;
  bit              exp_stall = 1'b0, exp_req = 1'b0, exp_bwe = 1'b0;
  logic [31:0]     exp_baddr = '0;
  logic [7:0]      exp_be = '0;
  logic [63:0]     exp_bdata = '0;
  int              stall_cnt = 0, req_cnt = 0;
  logic [63:0]     last_wdata = '0, last_bdata = '0;
  logic [31:0]     last_baddr = '0;
  logic [7:0]      last_be = '0;
  logic [4:0]      last_waddr = '0;
  logic            last_we = 1'b0, last_mis = 1'b0, last_flt = 1'b0;
  longint unsigned cyc = 0;
  int              n_vec = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the expectations posted by the driver.
  always @(negedge clk) begin
    res_t r;
    if (chk_en) begin
      if (o_stall) stall_cnt++;
      if (o_req) req_cnt++;
      check("stall_o", 64'(o_stall), 64'(exp_stall));
      check("dmem_req_o", 64'(o_req), 64'(exp_req));
      if (exp_req) begin
        check("dmem_addr_o", 64'(o_baddr), 64'(exp_baddr));
        check("dmem_be_o", 64'(o_be), 64'(exp_be));
        check("dmem_we_o", 64'(o_bwe), 64'(exp_bwe));
        check("dmem_wdata_o", o_bdata, exp_bdata);
        last_baddr = o_baddr;
        last_be    = o_be;
        last_bdata = o_bdata;
      end
      if (q.size() != 0 && q[0].due == cyc) begin
        r = q.pop_front();
        check("valid_o", 64'(o_valid), 64'(1));
        check("reg_we_o", 64'(o_rwe), 64'(r.we));
        check("exc_misaligned_o", 64'(o_mis), 64'(r.mis));
        check("exc_fault_o", 64'(o_flt), 64'(r.flt));
        if (r.chk) begin
          check("reg_waddr_o", 64'(o_waddr), 64'(r.wa));
          check("reg_wdata_o", o_wdata, r.d);
        end
        last_wdata = o_wdata;
        last_waddr = o_waddr;
        last_we    = o_rwe;
        last_mis   = o_mis;
        last_flt   = o_flt;
      end else begin
        check("valid_o_idle", 64'(o_valid), 64'(0));
        check("exc_idle", 64'({o_mis, o_flt}), 64'(0));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input bit v);
    if (sel64) v64 = v; else v32 = v;
  endtask

  task automatic set_ack(input bit a);
    if (sel64) ack64 = a; else ack32 = a;
  endtask

  task automatic idle(input int n);
    set_valid(1'b0);
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    repeat (n) tick();
  endtask

  // Access size in bytes (0 = no memory access) for the active width.
  function automatic void model_dec(input logic [3:0] o, input bit is64,
                                    output bit ld, output bit st, output int sz);
    ld = 1'b0; st = 1'b0; sz = 0;
    case (o)
      4'd1, 4'd4: begin ld = 1'b1; sz = 1; end
      4'd2, 4'd5: begin ld = 1'b1; sz = 2; end
      4'd3:       begin ld = 1'b1; sz = 4; end
      4'd6:       begin st = 1'b1; sz = 1; end
      4'd7:       begin st = 1'b1; sz = 2; end
      4'd8:       begin st = 1'b1; sz = 4; end
      4'd9:       if (is64) begin ld = 1'b1; sz = 4; end
      4'd10:      if (is64) begin ld = 1'b1; sz = 8; end
      4'd11:      if (is64) begin st = 1'b1; sz = 8; end
      default: ;
    endcase
  endfunction

  function automatic logic [63:0] model_load(input logic [3:0] o, input logic [63:0] rd,
                                             input int off, input bit is64);
    logic [63:0] m, sh, v;
    m  = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    sh = (rd & m) >> (8 * off);
    case (o)
      4'd1:    v = longint'($signed(sh[7:0]));
      4'd4:    v = 64'(sh[7:0]);
      4'd2:    v = longint'($signed(sh[15:0]));
      4'd5:    v = 64'(sh[15:0]);
      4'd3:    v = longint'($signed(sh[31:0]));
      4'd9:    v = 64'(sh[31:0]);
      default: v = sh;
    endcase
    return v & m;
  endfunction

  // Drives one instruction and posts the expected stall/bus/result behaviour.
  // lat = BUS cycle index carrying ack, -1 for no ack at all.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [63:0] wd,
                       input logic [4:0] wa, input bit we, input logic [63:0] alu,
                       input int lat, input bit e, input logic [63:0] rd);
    bit          ld, st;
    int          sz, nb, off;
    logic [63:0] m;
    res_t        r;
    nb = sel64 ? 8 : 4;
    m  = sel64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    model_dec(o, sel64, ld, st, sz);
    op = o; addr = a; wdata = wd; waddr = wa; rwe = we; rwdata = alu;
    set_valid(1'b1);
    r.due = cyc + 1; r.we = 1'b0; r.mis = 1'b0; r.flt = 1'b0; r.chk = 1'b0; r.wa = wa; r.d = '0;
    exp_req = 1'b0;
    if (!(ld || st)) begin
      exp_stall = 1'b0;
      r.we = we; r.chk = 1'b1; r.d = alu & m;
      q.push_back(r);
      tick();
    end else if ((int'(a[2:0]) % sz) != 0) begin
      exp_stall = 1'b0;
      r.mis = 1'b1;
      q.push_back(r);
      tick();
    end else begin
      off       = int'(a[2:0]) % nb;
      exp_stall = 1'b1;
      exp_baddr = a & ~32'(nb - 1);
      exp_bwe   = st;
      exp_be    = '0;
      exp_bdata = '0;
      for (int i = 0; i < nb; i++) begin
        exp_be[i]            = (i >= off) && (i < off + sz);
        exp_bdata[8*i +: 8]  = wd[8*(i % sz) +: 8];
      end
      tick();
      exp_req = 1'b1;
      for (int k = 0; k < TO + 2; k++) begin
        if (k == lat) begin
          set_ack(1'b1); err = e; rdata = rd;
          exp_stall = 1'b0;
          r.due = cyc + 1;
          if (e) r.flt = 1'b1;
          else if (ld) begin r.we = 1'b1; r.chk = 1'b1; r.d = model_load(o, rd, off, sel64); end
          q.push_back(r);
          tick();
          set_ack(1'b0); err = 1'b0;
          break;
        end else if (k == TO - 1) begin
          exp_stall = 1'b0;
          r.due = cyc + 1; r.flt = 1'b1;
          q.push_back(r);
          tick();
          break;
        end else begin
          exp_stall = 1'b1;
          tick();
        end
      end
      exp_req = 1'b0;
    end
    set_valid(1'b0);
    exp_stall = 1'b0;
  endtask

  task automatic random_ops(input int n);
    logic [3:0]  o;
    logic [31:0] a;
    bit          ld, st;
    int          sz, r, lat;
    for (int i = 0; i < n; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      model_dec(o, sel64, ld, st, sz);
      if (sz != 0 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      r = $urandom_range(0, 39);
      if (r < 34)      lat = r % 4;
      else if (r < 36) lat = -1;
      else if (r < 38) lat = TO - 1;
      else             lat = TO - 2;
      do_op(o, a, {$urandom, $urandom}, 5'($urandom), 1'($urandom), {$urandom, $urandom},
            lat, ($urandom_range(0, 9) == 0), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  initial begin
    op = '0; addr = '0; wdata = '0; rwdata = '0; rdata = '0; waddr = '0;
    rwe = 1'b0; err = 1'b0; v32 = 1'b0; v64 = 1'b0; ack32 = 1'b0; ack64 = 1'b0;
    // Reset state, with an aligned load presented to show stall is held low.
    op = 4'd3; addr = 32'h100; v32 = 1'b1; v64 = 1'b1;
    repeat (2) tick();
    check("rst_stall32", 64'(s32), 64'(0));
    check("rst_stall64", 64'(s64), 64'(0));
    check("rst_req32", 64'(rq32), 64'(0));
    check("rst_req64", 64'(rq64), 64'(0));
    check("rst_outs32", 64'({vo32, rwe32, mis32, flt32, wa32, ro32}), 64'(0));
    check("rst_outs64", 64'({vo64, rwe64, mis64, flt64}), 64'(0));
    check("rst_wdata64", ro64, 64'(0));
    v32 = 1'b0; v64 = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    sel64 = 1'b0;
    do_op(4'd0, 32'h0, 64'h0, 5'd5, 1'b1, 64'h1234_5678, 0, 1'b0, 64'h0);
    idle(1);
    check("none_wdata", last_wdata, 64'h1234_5678);
    check("none_waddr", 64'(last_waddr), 64'd5);

    stall_cnt = 0;
    do_op(4'd1, 32'h1003, 64'h0, 5'd7, 1'b0, 64'h0, 2, 1'b0, 64'h80AA_BBCC);
    idle(1);
    check("lb_data", last_wdata, 64'hFFFF_FF80);
    check("lb_stall_cycles", 64'(stall_cnt), 64'd3);
    check("lb_be", 64'(last_be), 64'h8);
    check("lb_addr", 64'(last_baddr), 64'h1000);
    do_op(4'd4, 32'h1003, 64'h0, 5'd7, 1'b0, 64'h0, 2, 1'b0, 64'h80AA_BBCC);
    idle(1);
    check("lbu_data", last_wdata, 64'h0000_0080);

    do_op(4'd7, 32'h2002, 64'hDEAD_BEEF, 5'd3, 1'b1, 64'h0, 1, 1'b0, 64'h0);
    idle(1);
    check("sh_wdata", last_bdata, 64'hBEEF_BEEF);
    check("sh_be", 64'(last_be), 64'hC);
    check("sh_reg_we", 64'(last_we), 64'd0);

    req_cnt = 0;
    do_op(4'd3, 32'h3001, 64'h0, 5'd4, 1'b1, 64'h0, 0, 1'b0, 64'h0);
    idle(1);
    check("lw_mis_req", 64'(req_cnt), 64'd0);
    check("lw_mis_exc", 64'(last_mis), 64'd1);

    req_cnt = 0;
    do_op(4'd3, 32'h4000, 64'h0, 5'd4, 1'b1, 64'h0, -1, 1'b0, 64'h0);
    idle(1);
    check("timeout_req_cycles", 64'(req_cnt), 64'd16);
    check("timeout_fault", 64'(last_flt), 64'd1);
    do_op(4'd3, 32'h4000, 64'h0, 5'd4, 1'b1, 64'h0, 0, 1'b1, 64'h0);
    idle(1);
    check("err_fault", 64'({last_flt, last_we}), 64'b10);
    do_op(4'd3, 32'h4004, 64'h0, 5'd4, 1'b1, 64'h0, TO - 1, 1'b0, 64'h0BAD_F00D);
    idle(1);
    check("ack_beats_timeout", 64'({last_flt, last_we}), 64'b01);
    check("ack_beats_timeout_data", last_wdata, 64'h0BAD_F00D);
    do_op(4'd10, 32'h8, 64'h0, 5'd9, 1'b1, 64'h5555, 0, 1'b0, 64'h0);
    idle(1);
    check("ld_on_32_is_none", last_wdata, 64'h5555);

    // Reset in the middle of a bus access, then a stray ack.
    chk_en = 1'b0;
    op = 4'd3; addr = 32'h7000; v32 = 1'b1;
    tick();
    tick();
    check("req_before_rst", 64'(rq32), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", 64'(rq32), 64'd0);
    check("rst_mid_stall", 64'(s32), 64'd0);
    check("rst_mid_valid", 64'(vo32), 64'd0);
    tick();
    v32 = 1'b0;
    rst_n = 1'b1;
    ack32 = 1'b1;
    exp_stall = 1'b0; exp_req = 1'b0;
    chk_en = 1'b1;
    tick();
    ack32 = 1'b0;
    tick();
    do_op(4'd0, 32'h0, 64'h0, 5'd11, 1'b1, 64'hCAFE_0001, 0, 1'b0, 64'h0);
    idle(1);
    check("post_rst_none", last_wdata, 64'hCAFE_0001);

    random_ops(250);
    idle(2);

    sel64 = 1'b1;
    do_op(4'd10, 32'h5008, 64'h0, 5'd1, 1'b0, 64'h0, 1, 1'b0, 64'h8123_4567_89AB_CDEF);
    idle(1);
    check("ld_data", last_wdata, 64'h8123_4567_89AB_CDEF);
    do_op(4'd3, 32'h5004, 64'h0, 5'd2, 1'b0, 64'h0, 0, 1'b0, 64'h9000_0001_0000_0000);
    idle(1);
    check("lw64_sext", last_wdata, 64'hFFFF_FFFF_9000_0001);
    do_op(4'd9, 32'h5004, 64'h0, 5'd2, 1'b0, 64'h0, 0, 1'b0, 64'h9000_0001_0000_0000);
    idle(1);
    check("lwu_zext", last_wdata, 64'h0000_0000_9000_0001);
    do_op(4'd11, 32'h6000, 64'h1122_3344_5566_7788, 5'd2, 1'b0, 64'h0, 2, 1'b0, 64'h0);
    idle(1);
    check("sd_be", 64'(last_be), 64'hFF);
    check("sd_wdata", last_bdata, 64'h1122_3344_5566_7788);
    do_op(4'd10, 32'h5004, 64'h0, 5'd2, 1'b0, 64'h0, 0, 1'b0, 64'h0);
    idle(1);
    check("ld_misaligned", 64'(last_mis), 64'd1);

    random_ops(250);
    idle(2);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
